// File: rtl/frame_capture_if.sv
// Frame capture control bundle: register-block controls, camera/DMA
// handshakes and the status readback returned to the APB3 path.
//   cam_dma_init_done        DMA configured; low aborts the controller
//   trigger_capture_frame    level; rising edge requests one frame
//   continuous_capture_frame level; high re-arms after every frame
//   cam_vsync                frame-start strobe, synchronous to clk
//   dma_frame_done           one-cycle pulse, DMA finished a frame
//   capture_en               gates pixel writes into the DMA FIFO
//   dma_start                one-cycle pulse, start DMA frame transfer
//   frames_per_second        completed frames in the last full window
//   capture_status           debug/status word
interface frame_capture_if;
  logic        cam_dma_init_done;
  logic        trigger_capture_frame;
  logic        continuous_capture_frame;
  logic        cam_vsync;
  logic        dma_frame_done;
  logic        capture_en;
  logic        dma_start;
  logic [31:0] frames_per_second;
  logic [31:0] capture_status;

  // Controller side
  modport master (
    input  cam_dma_init_done,
    input  trigger_capture_frame,
    input  continuous_capture_frame,
    input  cam_vsync,
    input  dma_frame_done,
    output capture_en,
    output dma_start,
    output frames_per_second,
    output capture_status
  );

  // Register block / camera / DMA side
  modport slave (
    output cam_dma_init_done,
    output trigger_capture_frame,
    output continuous_capture_frame,
    output cam_vsync,
    output dma_frame_done,
    input  capture_en,
    input  dma_start,
    input  frames_per_second,
    input  capture_status
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Sequences camera frame capture into the camera DMA: aligns capture to
// vsync, issues one DMA start per frame, watches DMA completion with a
// timeout, measures frames per second and builds the status word.
//   clk     system clock
//   resetn  asynchronous, active-low reset
//   bus     frame_capture_if.master (controls in; capture_en, dma_start,
//           frames_per_second, capture_status out, all registered)
module frame_capture_ctrl #(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 16777215
) (
  input  logic            clk,
  input  logic            resetn,
  frame_capture_if.master bus
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned FT_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURE  = 2'd2,
    WAIT_DMA = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              trig_q, vs_q;
  logic              trig_edge, vs_edge;
  logic              pending, timeout_err, done_early;
  logic [FT_W-1:0]   frame_total;
  logic [CNT_W-1:0]  tmo_cnt, win_cnt, win_frames, fps_q;
  logic [31:0]       status_q;
  logic              capture_en_q, dma_start_q;
  logic              complete, timeout_hit, arm_from_idle;

  assign trig_edge = bus.trigger_capture_frame & ~trig_q;
  assign vs_edge   = bus.cam_vsync & ~vs_q;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and per-cycle events
  always_comb begin
    state_nxt     = state;
    complete      = 1'b0;
    timeout_hit   = 1'b0;
    arm_from_idle = 1'b0;
    if (!bus.cam_dma_init_done) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trig_edge | pending | bus.continuous_capture_frame) begin
            state_nxt     = ARMED;
            arm_from_idle = 1'b1;
          end
        end
        ARMED:   if (vs_edge) state_nxt = CAPTURE;
        CAPTURE: if (vs_edge) state_nxt = WAIT_DMA;
        WAIT_DMA: begin
          // A completion coincident with the timeout wins
          if (bus.dma_frame_done | done_early)
            complete = 1'b1;
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES))
            timeout_hit = 1'b1;
          if (complete | timeout_hit)
            state_nxt = bus.continuous_capture_frame ? ARMED : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Flags, counters and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trig_q       <= 1'b0;
      vs_q         <= 1'b0;
      pending      <= 1'b0;
      timeout_err  <= 1'b0;
      done_early   <= 1'b0;
      frame_total  <= '0;
      tmo_cnt      <= '0;
      win_cnt      <= '0;
      win_frames   <= '0;
      fps_q        <= '0;
      status_q     <= '0;
      capture_en_q <= 1'b0;
      dma_start_q  <= 1'b0;
    end else begin
      trig_q <= bus.trigger_capture_frame;
      vs_q   <= bus.cam_vsync;

      // One-deep request queue; consumed by any arming from IDLE
      if (!bus.cam_dma_init_done || arm_from_idle) pending <= 1'b0;
      else if (trig_edge && state != IDLE)          pending <= 1'b1;

      if (arm_from_idle && trig_edge) timeout_err <= 1'b0;
      else if (timeout_hit)           timeout_err <= 1'b1;

      if (!bus.cam_dma_init_done)                           done_early <= 1'b0;
      else if (state == CAPTURE && bus.dma_frame_done)      done_early <= 1'b1;
      else if (state == WAIT_DMA && state_nxt != WAIT_DMA)  done_early <= 1'b0;

      frame_total <= frame_total + FT_W'(complete);

      // Cleared outside WAIT_DMA so every entry starts from zero
      tmo_cnt <= (state == WAIT_DMA) ? tmo_cnt + CNT_W'(1) : '0;

      // Free-running FPS window; a completion on the wrap cycle still counts
      if (win_cnt == CNT_W'(CLK_FREQ_HZ - 1)) begin
        win_cnt    <= '0;
        fps_q      <= win_frames + CNT_W'(complete);
        win_frames <= '0;
      end else begin
        win_cnt    <= win_cnt + CNT_W'(1);
        win_frames <= win_frames + CNT_W'(complete);
      end

      // Registered from next state so they line up with state == CAPTURE
      capture_en_q <= (state_nxt == CAPTURE);
      dma_start_q  <= (state_nxt == CAPTURE) && (state != CAPTURE);

      status_q <= {frame_total, 10'd0, bus.cam_dma_init_done, done_early,
                   timeout_err, pending, state};
    end
  end

  assign bus.capture_en        = capture_en_q;
  assign bus.dma_start         = dma_start_q;
  assign bus.frames_per_second = fps_q;
  assign bus.capture_status    = status_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: single shot, timeout, queued
// trigger, abort, asynchronous reset, continuous mode with FPS window.
module tb_frame_capture_ctrl;

  logic clk = 1'b0;
  logic resetn;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_ds     = 0;
  int   n_ce     = 0;

  frame_capture_if bus ();

  frame_capture_ctrl #(
    .CLK_FREQ_HZ   (10000),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    n_ds += int'(bus.dma_start);
    n_ce += int'(bus.capture_en);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vs_pulse();
    bus.cam_vsync = 1'b1;
    tick();
    bus.cam_vsync = 1'b0;
  endtask

  task automatic trig_pulse();
    bus.trigger_capture_frame = 1'b1;
    tick();
    bus.trigger_capture_frame = 1'b0;
  endtask

  task automatic done_pulse();
    bus.dma_frame_done = 1'b1;
    tick();
    bus.dma_frame_done = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn                       = 1'b0;
    bus.cam_dma_init_done        = 1'b0;
    bus.trigger_capture_frame    = 1'b0;
    bus.continuous_capture_frame = 1'b0;
    bus.cam_vsync                = 1'b0;
    bus.dma_frame_done           = 1'b0;

    // Reset state
    ticks(2);
    check("rst_status", bus.capture_status, 32'h0);
    check("rst_fps", bus.frames_per_second, 32'h0);
    check("rst_capture_en", 32'(bus.capture_en), 32'h0);
    check("rst_dma_start", 32'(bus.dma_start), 32'h0);
    resetn = 1'b1;
    tick();

    // Single shot
    bus.cam_dma_init_done = 1'b1;
    trig_pulse();
    ticks(5);
    check("ss_armed", bus.capture_status, 32'h0000_0021);
    n_ds = 0;
    n_ce = 0;
    vs_pulse();
    check("ss_dma_start", 32'(bus.dma_start), 32'h1);
    check("ss_capture_en", 32'(bus.capture_en), 32'h1);
    ticks(999);
    vs_pulse();
    check("ss_capture_end", 32'(bus.capture_en), 32'h0);
    check("ss_ce_cycles", 32'(n_ce), 32'd1000);
    check("ss_ds_count", 32'(n_ds), 32'd1);
    ticks(49);
    done_pulse();
    check("ss_status_lag", bus.capture_status, 32'h0000_0023);
    tick();
    check("ss_done", bus.capture_status, 32'h0001_0020);

    // Timeout without dma_frame_done
    trig_pulse();
    vs_pulse();
    ticks(9);
    vs_pulse();
    ticks(101);
    check("to_before", bus.capture_status, 32'h0001_0023);
    tick();
    check("to_raised", bus.capture_status, 32'h0001_0028);
    trig_pulse();
    tick();
    check("to_cleared", bus.capture_status, 32'h0001_0021);

    // Trigger edge during CAPTURE is queued and re-arms after completion
    n_ds = 0;
    vs_pulse();
    ticks(10);
    trig_pulse();
    tick();
    check("pend_set", bus.capture_status, 32'h0001_0026);
    ticks(20);
    vs_pulse();
    ticks(5);
    done_pulse();
    tick();
    check("pend_idle", bus.capture_status, 32'h0002_0024);
    tick();
    check("pend_rearm", bus.capture_status, 32'h0002_0021);
    vs_pulse();
    ticks(20);
    vs_pulse();
    ticks(3);
    done_pulse();
    ticks(2);
    check("pend_final", bus.capture_status, 32'h0003_0020);
    check("pend_ds_count", 32'(n_ds), 32'd2);

    // Abort by dropping cam_dma_init_done mid-CAPTURE
    trig_pulse();
    vs_pulse();
    ticks(5);
    bus.cam_dma_init_done = 1'b0;
    tick();
    check("abort_capture_en", 32'(bus.capture_en), 32'h0);
    tick();
    check("abort_status", bus.capture_status, 32'h0003_0000);
    bus.cam_dma_init_done = 1'b1;
    ticks(2);
    n_ds = 0;
    done_pulse();
    vs_pulse();
    ticks(3);
    check("abort_no_start", 32'(n_ds), 32'd0);
    check("abort_idle", bus.capture_status, 32'h0003_0020);

    // Asynchronous reset during WAIT_DMA
    trig_pulse();
    vs_pulse();
    ticks(5);
    vs_pulse();
    ticks(3);
    check("rm_wait", bus.capture_status, 32'h0003_0023);
    resetn = 1'b0;
    #1;
    check("rm_status", bus.capture_status, 32'h0);
    check("rm_fps", bus.frames_per_second, 32'h0);
    check("rm_capture_en", 32'(bus.capture_en), 32'h0);
    check("rm_dma_start", 32'(bus.dma_start), 32'h0);
    ticks(2);

    // Continuous mode: frame every 2000 cycles, 10000-cycle FPS window
    bus.continuous_capture_frame = 1'b1;
    resetn = 1'b1;
    ticks(10);
    n_ds = 0;
    for (int f = 0; f < 11; f++) begin
      vs_pulse();
      ticks(999);
      vs_pulse();
      ticks(19);
      done_pulse();
      ticks(979);
      if (f == 3) check("cont_fps_w0", bus.frames_per_second, 32'd0);
      if (f == 4) check("cont_fps_w1", bus.frames_per_second, 32'd5);
    end
    check("cont_fps_w2", bus.frames_per_second, 32'd5);
    check("cont_status", bus.capture_status, 32'h000B_0021);
    check("cont_ds_count", 32'(n_ds), 32'd11);

    // Continuous turned off mid-frame: frame finishes, then IDLE
    vs_pulse();
    ticks(100);
    bus.continuous_capture_frame = 1'b0;
    ticks(100);
    vs_pulse();
    ticks(19);
    done_pulse();
    ticks(2);
    check("cont_off_idle", bus.capture_status, 32'h000C_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequences camera frame capture into the camera DMA under software control. It takes the single-shot trigger, continuous-mode and DMA-ready controls from the APB3 register block. It aligns capture to camera frame boundaries (vsync), issues one DMA start per frame and watches for DMA completion with a timeout. It also measures frames per second and returns a status word to the APB3 readback path.

## Interface
Parameters:
- CLK_FREQ_HZ, 100000000, length of the FPS measurement window in clk cycles
- TIMEOUT_CYCLES, 16777215, maximum clk cycles in WAIT_DMA before the timeout error is raised

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- cam_dma_init_done  in  1  DMA configured; low forces abort/IDLE
- trigger_capture_frame  in  1  level from register; rising edge requests one frame
- continuous_capture_frame  in  1  level; high re-arms after every frame
- cam_vsync  in  1  frame-start strobe, already synchronous to clk
- dma_frame_done  in  1  one-cycle pulse, DMA finished writing a frame
- capture_en  out  1  gates pixel writes into the DMA FIFO
- dma_start  out  1  one-cycle pulse, start DMA frame transfer
- frames_per_second  out  32  completed frames in the last full window
- capture_status  out  32  debug/status word

## Operation
- Edge detect: trig_edge = trigger & ~trig_q; vs_edge = cam_vsync & ~vs_q. Both _q registers reset to 0.
- States: IDLE(0), ARMED(1), CAPTURE(2), WAIT_DMA(3).
- IDLE -> ARMED on (trig_edge | pending | continuous) & cam_dma_init_done. Clears pending and timeout_err when entered via trig_edge.
- ARMED -> CAPTURE on vs_edge. dma_start pulses in the first CAPTURE cycle.
- CAPTURE -> WAIT_DMA on the next vs_edge. A dma_frame_done during CAPTURE sets done_early.
- WAIT_DMA exit conditions:
  - On dma_frame_done or done_early: frame complete. Increment frame_total (16-bit, wraps) and the window count.
  - On timeout counter == TIMEOUT_CYCLES: set sticky timeout_err. The frame is not counted.
  - Exit destination: ARMED if continuous, else IDLE.
- Entry to WAIT_DMA clears the timeout counter. done_early clears on WAIT_DMA exit.
- pending: set by trig_edge in any state other than IDLE. It is one-deep; further edges are dropped.
- cam_dma_init_done low, in any state: the next state is IDLE. Clears pending and done_early. capture_en drops the next cycle. No dma_start is issued.
- FPS:
  - window counter runs 0..CLK_FREQ_HZ-1 continuously from reset.
  - At wrap, frames_per_second <= window count, including a completion in the same cycle.
  - The window count then restarts at 0.
- capture_status:
  - [1:0] state
  - [2] pending
  - [3] timeout_err
  - [4] done_early
  - [5] cam_dma_init_done
  - [15:6] 0
  - [31:16] frame_total

## Timing
- Reset values: state IDLE, capture_en 0, dma_start 0, frames_per_second 0, capture_status 0, all counters 0.
- All outputs are registered.
- capture_en = 1 exactly in the cycles where state==CAPTURE, i.e. from the cycle after the starting vs_edge through the cycle of the ending vs_edge.
- ARMED->CAPTURE latency is 1 cycle after vs_edge. A vsync high while IDLE or in the same cycle as arming is not a start edge.
- dma_start is high for exactly 1 cycle per CAPTURE entry.
- Completion is counted on the cycle after the dma_frame_done sample. frame_total is visible in status 1 cycle later.
- A dma_frame_done outside CAPTURE/WAIT_DMA is ignored.
- A dma_frame_done coincident with timeout counts as complete; no error is raised.
- Continuous mode turned off during a frame: the current frame finishes, then IDLE.

## Test plan
- Single shot: cam_dma_init_done=1, trigger 0->1, vsync pulses at t0, t0+1000, done 50 cycles later.
  - dma_start once at t0+1.
  - capture_en high for 1000 cycles.
  - Return to IDLE.
  - status[31:16]=1.
- Continuous mode with CLK_FREQ_HZ=10000 (sim override), vsync period 1000, done 20 cycles after each frame end.
  - Frames complete on every second vsync, so 5 frames per window.
  - frames_per_second=5 after the second window.
- Timeout with TIMEOUT_CYCLES=100 and no dma_frame_done.
  - status[3]=1 after 100 WAIT_DMA cycles.
  - State IDLE; frame_total unchanged.
  - The next trigger edge clears status[3].
- Trigger edge during CAPTURE:
  - status[2]=1.
  - After completion the controller re-arms automatically and captures a second frame.
  - Then IDLE with pending 0.
- Abort: drop cam_dma_init_done mid-CAPTURE.
  - capture_en=0 next cycle; state IDLE.
  - A vsync pulse then produces no dma_start.
- Reset mid-operation: assert resetn low during WAIT_DMA.
  - All outputs return to 0 immediately (asynchronously).
  - frames_per_second=0.
